alu_op_sequencer: RTL and testbench

Command-side initiator for the combinational 64-bit ALU (A/B operands, 4-bit select, result, zero flag). It accepts register-to-register commands over a valid/ready port and reads operands from an internal register file. It drives the ALU, captures the result and zero flag, writes back to the register file, and returns a response over a valid/ready port. A host load port preloads registers, and a read port exposes register contents for inspection.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_seq_regfile.sv | 30 +++
 rtl/alu_op_sequencer.sv | 93 +++++++++
 tb/tb_alu_op_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode constants and sequencer FSM encoding shared by the ALU command sequencer.
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_OPER, S_RESP} state_t;
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: register file with two operand read ports, one inspection port, one write port.
module alu_seq_regfile #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [IDX_W-1:0]  ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic [IDX_W-1:0]  ra3,
  output logic [DATA_W-1:0] rd3
);
  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    else if (we)
      mem[waddr] <= wdata;

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
  assign rd3 = mem[ra3];
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts register-to-register commands, drives an external ALU,
// writes back the result and returns a response with a saturating completion count.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREGS  = 8,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_rd,
  input  logic [IDX_W-1:0]  cmd_rs1,
  input  logic [IDX_W-1:0]  cmd_rs2,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  op_count
);
  state_t state, state_nx;
  logic [IDX_W-1:0]  rd_q;
  logic [DATA_W-1:0] rs1_val, rs2_val, wdata;
  logic [IDX_W-1:0]  waddr;
  logic accept, ld_do, div0, wb, we;

  assign cmd_ready = state == S_IDLE;
  assign ld_ready  = state == S_IDLE && !cmd_valid;
  assign rsp_valid = state == S_RESP;
  assign accept    = cmd_valid && cmd_ready;
  assign ld_do     = ld_valid && ld_ready;
  assign div0      = alu_sel == OP_DIV && alu_b == '0;
  assign wb        = state == S_OPER && !div0;
  // Loads only happen in IDLE and writeback only in OPER, so they never collide.
  assign we        = wb || ld_do;
  assign waddr     = wb ? rd_q : ld_idx;
  assign wdata     = wb ? alu_out : ld_data;

  alu_seq_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .IDX_W(IDX_W)) u_rf (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .ra1(cmd_rs1), .rd1(rs1_val), .ra2(cmd_rs2), .rd2(rs2_val),
    .ra3(rd_idx), .rd3(rd_data)
  );

  always_comb
    state_nx = state == S_IDLE ? (accept ? S_OPER : S_IDLE) :
               state == S_OPER ? S_RESP :
               rsp_ready ? S_IDLE : S_RESP;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= S_IDLE;
      rd_q     <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rd_q    <= cmd_rd;
        alu_a   <= rs1_val;
        alu_b   <= rs2_val;
        alu_sel <= cmd_op;
      end
      if (state == S_OPER) begin
        rsp_data <= div0 ? '0 : alu_out;
        rsp_zero <= div0 ? 1'b0 : alu_z;
        rsp_err  <= div0;
      end
      if (rsp_valid && rsp_ready && op_count != '1)
        op_count <= op_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench with a behavioural ALU, shadow register model and response scoreboard.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic        zero;
    logic        err;
    logic [2:0]  rd;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [2:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic        ld_valid = 1'b0, ld_ready;
  logic [2:0]  ld_idx = '0;
  logic [63:0] ld_data = '0;
  logic [2:0]  rd_idx = '0;
  logic [63:0] rd_data, alu_a, alu_b, alu_out, rsp_data;
  logic [3:0]  alu_sel;
  logic        alu_z, rsp_valid, rsp_ready = 1'b0, rsp_zero, rsp_err;
  logic [15:0] op_count;

  int vectors = 0, miscompares = 0, exp_cnt = 0;
  logic [63:0] model [8];
  exp_t sb [$];
  exp_t cur;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_idx(ld_idx), .ld_data(ld_data), .rd_idx(rd_idx), .rd_data(rd_data), .alu_a(alu_a),
    .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_z(alu_z), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  function automatic logic [63:0] alu_f(logic [63:0] a, logic [63:0] b, logic [3:0] s);
    logic [127:0] aa;
    aa = {a, a};
    case (s)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_DIV:  return b == 0 ? '1 : a / b;
      OP_SHL:  return a << b[5:0];
      OP_SHR:  return a >> b[5:0];
      OP_ROL:  begin aa = aa << b[5:0]; return aa[127:64]; end
      OP_ROR:  begin aa = aa >> b[5:0]; return aa[63:0]; end
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_NAND: return ~(a & b);
      OP_XNOR: return ~(a ^ b);
      OP_GT:   return {63'b0, a > b};
      default: return {63'b0, a == b};
    endcase
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_sel);
  assign alu_z   = alu_out == 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(logic [2:0] idx, logic [63:0] exp, string tag);
    rd_idx = idx;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic load(logic [2:0] idx, logic [63:0] data);
    ld_valid = 1'b1; ld_idx = idx; ld_data = data;
    tick();
    ld_valid = 1'b0;
    model[idx] = data;
  endtask

  function automatic exp_t predict(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2);
    exp_t e;
    logic [63:0] r;
    r = alu_f(model[rs1], model[rs2], op);
    e.err  = op == OP_DIV && model[rs2] == 0;
    e.data = e.err ? '0 : r;
    e.zero = e.err ? 1'b0 : r == 0;
    e.rd   = rd;
    return e;
  endfunction

  task automatic drive_cmd(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    sb.push_back(predict(op, rd, rs1, rs2));
  endtask

  task automatic issue(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2);
    drive_cmd(op, rd, rs1, rs2);
    tick();
    cmd_valid = 1'b0;
    check("alu_sel_at_accept", {60'b0, alu_sel}, {60'b0, op});
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    check("rsp_valid_timeout", {63'b0, rsp_valid}, 64'd1);
    cur = sb.pop_front();
  endtask

  task automatic check_rsp(string tag);
    check({tag, "_data"}, rsp_data, cur.data);
    check({tag, "_zero"}, {63'b0, rsp_zero}, {63'b0, cur.zero});
    check({tag, "_err"},  {63'b0, rsp_err},  {63'b0, cur.err});
    if (!cur.err) model[cur.rd] = cur.data;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_cnt++;
    check("rsp_valid_drop", {63'b0, rsp_valid}, 64'd0);
    check("op_count", {48'b0, op_count}, exp_cnt);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (3) tick();
    check("rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    check("rst_ld_ready", {63'b0, ld_ready}, 64'd1);
    check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("rst_alu_a", alu_a, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_op_count", {48'b0, op_count}, 64'd0);

    // ADD with exact latency checks
    load(3'd1, 64'd10); load(3'd2, 64'd3);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2);
    check("oper_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("oper_cmd_ready", {63'b0, cmd_ready}, 64'd0);
    tick();
    check("resp_rsp_valid", {63'b0, rsp_valid}, 64'd1);
    wait_rsp(); check_rsp("add"); finish_rsp();
    peek(3'd3, 64'd13, "rf_r3");

    // SUB to zero, overwriting a preloaded destination
    load(3'd4, 64'd7); load(3'd5, 64'd7); load(3'd6, 64'd55);
    issue(OP_SUB, 3'd6, 3'd4, 3'd5);
    wait_rsp(); check_rsp("sub"); finish_rsp();
    peek(3'd6, 64'd0, "rf_r6");

    // DIV by zero: error, writeback suppressed
    load(3'd0, 64'd100);
    issue(OP_DIV, 3'd0, 3'd0, 3'd7);
    wait_rsp(); check_rsp("div0"); finish_rsp();
    peek(3'd0, 64'd100, "rf_r0_kept");

    // MUL held by backpressure, then back-to-back XOR
    load(3'd1, 64'd6); load(3'd2, 64'd7);
    issue(OP_MUL, 3'd5, 3'd1, 3'd2);
    wait_rsp();
    cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_rd = 3'd6; cmd_rs1 = 3'd5; cmd_rs2 = 3'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_data", rsp_data, 64'd42);
      check("hold_cmd_ready", {63'b0, cmd_ready}, 64'd0);
    end
    check_rsp("mul");
    sb.push_back(predict(OP_XOR, 3'd6, 3'd5, 3'd1));
    finish_rsp();
    check("b2b_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
    check("b2b_accept", {63'b0, cmd_ready}, 64'd0);
    check("b2b_alu_a", alu_a, 64'd42);
    wait_rsp(); check_rsp("xor"); finish_rsp();
    peek(3'd6, 64'd44, "rf_r6_xor");

    // Command beats load in the same cycle
    drive_cmd(OP_ADD, 3'd7, 3'd1, 3'd1);
    ld_valid = 1'b1; ld_idx = 3'd2; ld_data = 64'd99;
    #1;
    check("collide_ld_ready", {63'b0, ld_ready}, 64'd0);
    tick();
    cmd_valid = 1'b0; ld_valid = 1'b0;
    peek(3'd2, 64'd7, "collide_r2_kept");
    wait_rsp(); check_rsp("collide_add"); finish_rsp();
    load(3'd2, 64'd99);
    peek(3'd2, 64'd99, "late_load_r2");
    peek(3'd7, 64'd12, "rf_r7");

    // Reset during OPER
    issue(OP_SUB, 3'd3, 3'd2, 3'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("mrst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    check("mrst_op_count", {48'b0, op_count}, 64'd0);
    for (int i = 0; i < 8; i++) peek(3'(i), 64'd0, "mrst_rf");
    sb.delete();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    check("post_rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    peek(3'd3, 64'd0, "post_rst_no_wb");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
